// File: rtl/tick_seq_pkg.sv
// Shared definitions for the tick sequencer: FSM state encoding and default widths.
package tick_seq_pkg;

  localparam int DEF_NUM_CORES      = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_COUNT_W        = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_e;

  // A one-cycle timeout still needs a 1-bit counter to hold its zero value.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/tick_sequencer_if.sv
// Host/core-side signal bundle of the tick sequencer; master drives requests, slave is the sequencer.
interface tick_sequencer_if #(
  parameter int NUM_CORES = tick_seq_pkg::DEF_NUM_CORES,
  parameter int COUNT_W   = tick_seq_pkg::DEF_COUNT_W
);
  logic                 tick_req;
  logic [NUM_CORES-1:0] core_active_mask;
  logic [NUM_CORES-1:0] core_done;
  logic                 clear_error;
  logic [NUM_CORES-1:0] core_tick;
  logic                 tick_ack;
  logic                 tick_done;
  logic                 busy;
  logic [COUNT_W-1:0]   tick_count;
  logic                 error;
  logic [NUM_CORES-1:0] error_core;
  logic                 overrun;

  modport master (
    output tick_req, core_active_mask, core_done, clear_error,
    input  core_tick, tick_ack, tick_done, busy, tick_count, error, error_core, overrun
  );

  modport slave (
    input  tick_req, core_active_mask, core_done, clear_error,
    output core_tick, tick_ack, tick_done, busy, tick_count, error, error_core, overrun
  );
endinterface

// File: rtl/tick_timeout_counter.sv
// Wait-phase timeout counter: load clears, enable increments, terminal flags the last allowed cycle.
module tick_timeout_counter
  import tick_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic terminal
);
  localparam int TIMER_W = timer_width(TIMEOUT_CYCLES);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)        count_d = '0;
    else if (enable) count_d = count_q + 1'b1;
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign terminal = (count_q == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/tick_sequencer.sv
// Issues one tick to the active neuron cores, waits for every core's done pulse or a timeout.
module tick_sequencer
  import tick_seq_pkg::*;
#(
  parameter int NUM_CORES      = DEF_NUM_CORES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int COUNT_W        = DEF_COUNT_W
) (
  input logic             clk,
  input logic             rst,
  tick_sequencer_if.slave bus
);
  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [NUM_CORES-1:0] core_tick_q, core_tick_d;
  logic [NUM_CORES-1:0] error_core_q, error_core_d;
  logic [COUNT_W-1:0]   tick_count_q, tick_count_d;
  logic                 tick_ack_q, tick_ack_d;
  logic                 tick_done_q, tick_done_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;
  logic                 overrun_q, overrun_d;
  logic                 timer_load, timer_en, timer_tc;

  tick_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .enable   (timer_en),
    .terminal (timer_tc)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    error_d      = error_q;
    error_core_d = error_core_q;
    overrun_d    = overrun_q | (bus.tick_req && (state_q != IDLE));
    timer_load   = 1'b0;
    timer_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.tick_req) begin
          state_d    = ISSUE;
          pending_d  = bus.core_active_mask;
          timer_load = 1'b1;
        end
      end
      ISSUE: begin
        pending_d = pending_q & ~bus.core_done;
        state_d   = (pending_q == '0) ? DONE : WAIT;
      end
      WAIT: begin
        pending_d = pending_q & ~bus.core_done;
        // Completion is tested first so it wins over a same-edge timeout.
        if (pending_d == '0) begin
          state_d = DONE;
        end else if (timer_tc) begin
          state_d      = ERROR;
          error_d      = 1'b1;
          error_core_d = pending_d;
        end else begin
          timer_en = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      ERROR: begin
        if (bus.clear_error) begin
          state_d      = IDLE;
          error_d      = 1'b0;
          error_core_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output pulses are registered on entry so they align with the new state.
    core_tick_d  = (state_d == ISSUE) ? pending_d : '0;
    tick_ack_d   = (state_d == ISSUE);
    tick_done_d  = (state_d == DONE);
    tick_count_d = tick_done_d ? tick_count_q + 1'b1 : tick_count_q;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      core_tick_q  <= '0;
      error_core_q <= '0;
      tick_count_q <= '0;
      tick_ack_q   <= 1'b0;
      tick_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      core_tick_q  <= core_tick_d;
      error_core_q <= error_core_d;
      tick_count_q <= tick_count_d;
      tick_ack_q   <= tick_ack_d;
      tick_done_q  <= tick_done_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.core_tick  = core_tick_q;
  assign bus.tick_ack   = tick_ack_q;
  assign bus.tick_done  = tick_done_q;
  assign bus.busy       = busy_q;
  assign bus.tick_count = tick_count_q;
  assign bus.error      = error_q;
  assign bus.error_core = error_core_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer: 4 cores, 16-cycle timeout, 4-bit tick counter so wrap is reachable.
module tb_tick_sequencer;
  localparam int NC = 4;
  localparam int TO = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks    = 0;
  int   failures  = 0;
  int   exp_count = 0;

  tick_sequencer_if #(.NUM_CORES(NC), .COUNT_W(CW)) bus ();

  tick_sequencer #(.NUM_CORES(NC), .TIMEOUT_CYCLES(TO), .COUNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_core_tick"}, 32'(bus.core_tick), 32'd0);
    check({tag, "_tick_ack"}, 32'(bus.tick_ack), 32'd0);
    check({tag, "_tick_done"}, 32'(bus.tick_done), 32'd0);
  endtask

  // Empty-mask tick: ISSUE at cycle 1, DONE at cycle 2, IDLE at cycle 3.
  task automatic empty_tick(input bit verbose);
    bus.core_active_mask = '0;
    bus.tick_req         = 1'b1;
    step();
    bus.tick_req = 1'b0;
    if (verbose) begin
      check("t42_core_tick", 32'(bus.core_tick), 32'd0);
      check("t42_ack", 32'(bus.tick_ack), 32'd1);
      check("t42_done_c1", 32'(bus.tick_done), 32'd0);
    end
    step();
    exp_count = (exp_count + 1) % 16;
    if (verbose) begin
      check("t42_done_c2", 32'(bus.tick_done), 32'd1);
      check("t42_ack_c2", 32'(bus.tick_ack), 32'd0);
      check("t42_count", 32'(bus.tick_count), 32'(exp_count));
    end
    step();
  endtask

  initial begin
    rst                  = 1'b1;
    bus.tick_req         = 1'b0;
    bus.core_active_mask = '0;
    bus.core_done        = '0;
    bus.clear_error      = 1'b0;
    step();
    step();
    check_quiet("rst");
    check("rst_count", 32'(bus.tick_count), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    step();
    check_quiet("post_rst");

    // Full mask, done pulses at cycles 3,5,6,9 -> tick_done at cycle 10.
    bus.core_active_mask = 4'hF;
    bus.tick_req         = 1'b1;
    step();
    bus.tick_req = 1'b0;
    check("t40_core_tick", 32'(bus.core_tick), 32'hF);
    check("t40_ack", 32'(bus.tick_ack), 32'd1);
    check("t40_busy", 32'(bus.busy), 32'd1);
    for (int c = 1; c <= 9; c++) begin
      case (c)
        3:       bus.core_done = 4'b0001;
        5:       bus.core_done = 4'b0010;
        6:       bus.core_done = 4'b0100;
        9:       bus.core_done = 4'b1000;
        default: bus.core_done = 4'b0000;
      endcase
      if (c == 2) check("t40_core_tick_c2", 32'(bus.core_tick), 32'd0);
      if (c == 9) check("t40_done_c9", 32'(bus.tick_done), 32'd0);
      step();
    end
    bus.core_done = '0;
    exp_count     = 1;
    check("t40_done_c10", 32'(bus.tick_done), 32'd1);
    check("t40_count", 32'(bus.tick_count), 32'd1);
    step();
    check_quiet("t40_c11");

    // Empty mask: ack without core ticks, done one cycle later.
    empty_tick(1'b1);
    check_quiet("t42_c3");

    // Mask 0101 with only core 2 reporting -> timeout, error_core = core 0.
    bus.core_active_mask = 4'b0101;
    bus.tick_req         = 1'b1;
    step();
    bus.tick_req = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      bus.core_done = (c == 4) ? 4'b0100 : 4'b0000;
      if (c == 17) check("t41_error_c17", 32'(bus.error), 32'd0);
      step();
    end
    check("t41_error_c18", 32'(bus.error), 32'd1);
    check("t41_error_core", 32'(bus.error_core), 32'b0001);
    check("t41_busy", 32'(bus.busy), 32'd1);
    check("t41_no_done", 32'(bus.tick_done), 32'd0);
    repeat (3) step();
    check("t41_error_held", 32'(bus.error), 32'd1);
    bus.clear_error = 1'b1;
    step();
    bus.clear_error = 1'b0;
    check("t41_error_cleared", 32'(bus.error), 32'd0);
    check("t41_error_core_cleared", 32'(bus.error_core), 32'd0);
    check("t41_idle", 32'(bus.busy), 32'd0);
    check("t41_count", 32'(bus.tick_count), 32'(exp_count));

    // Done on the terminal timer cycle beats the timeout; clear_error held has no effect.
    bus.clear_error      = 1'b1;
    bus.core_active_mask = 4'b0001;
    bus.tick_req         = 1'b1;
    step();
    bus.tick_req = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      bus.core_done = (c == 17) ? 4'b0001 : 4'b0000;
      if (c == 17) check("prec_busy_c17", 32'(bus.busy), 32'd1);
      step();
    end
    bus.core_done   = '0;
    bus.clear_error = 1'b0;
    exp_count       = 3;
    check("prec_done", 32'(bus.tick_done), 32'd1);
    check("prec_error", 32'(bus.error), 32'd0);
    check("prec_count", 32'(bus.tick_count), 32'(exp_count));
    step();
    check("prec_overrun_clear", 32'(bus.overrun), 32'd0);

    // tick_req and core_done held high: one tick every 4 cycles, overrun after first busy cycle.
    bus.core_active_mask = 4'b0001;
    bus.core_done        = 4'b0001;
    bus.tick_req         = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      check($sformatf("t43_core_tick_c%0d", c), 32'(bus.core_tick), (c % 4 == 1) ? 32'd1 : 32'd0);
      check($sformatf("t43_tick_done_c%0d", c), 32'(bus.tick_done), (c % 4 == 3) ? 32'd1 : 32'd0);
      if (c == 1) check("t43_overrun_c1", 32'(bus.overrun), 32'd0);
      if (c == 2) check("t43_overrun_c2", 32'(bus.overrun), 32'd1);
    end
    bus.tick_req  = 1'b0;
    bus.core_done = '0;
    step();
    exp_count = 7;
    check("t43_idle", 32'(bus.busy), 32'd0);
    check("t43_count", 32'(bus.tick_count), 32'(exp_count));

    // Reset in the middle of WAIT clears everything; later done pulses are ignored.
    bus.core_active_mask = 4'hF;
    bus.tick_req         = 1'b1;
    step();
    bus.tick_req = 1'b0;
    step();
    check("rstw_busy", 32'(bus.busy), 32'd1);
    rst           = 1'b1;
    bus.core_done = 4'hF;
    step();
    rst       = 1'b0;
    exp_count = 0;
    check_quiet("rstw");
    check("rstw_count", 32'(bus.tick_count), 32'd0);
    check("rstw_overrun", 32'(bus.overrun), 32'd0);
    check("rstw_error", 32'(bus.error), 32'd0);
    check("rstw_error_core", 32'(bus.error_core), 32'd0);
    step();
    bus.core_done = '0;
    check_quiet("rstw_ignore");
    step();
    check("rstw_ignore_done", 32'(bus.tick_done), 32'd0);
    check("rstw_ignore_count", 32'(bus.tick_count), 32'd0);

    // Counter wrap: 15 ticks reach all-ones, one more wraps to zero.
    repeat (15) empty_tick(1'b0);
    check("wrap_max", 32'(bus.tick_count), 32'd15);
    empty_tick(1'b0);
    check("wrap_zero", 32'(bus.tick_count), 32'(exp_count));
    check("wrap_zero_abs", 32'(bus.tick_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_sequencer.md
TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 Parameter NUM_CORES, default 4: number of neuron cores sequenced.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: max cycles from tick issue to all-cores-done.
REQ-003 Parameter COUNT_W, default 32: tick counter width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-005 clk  in  1  rising-edge system clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 tick_req  in  1  host request to run one tick.
REQ-008 core_active_mask  in  NUM_CORES  cores participating; sampled at tick acceptance.
REQ-009 core_done  in  NUM_CORES  per-core single-cycle pulse when that core's scheduler clear is complete.
REQ-010 clear_error  in  1  host acknowledge of a timeout.
REQ-011 core_tick  out  NUM_CORES  single-cycle tick pulse to each active core.
REQ-012 tick_ack  out  1  single-cycle pulse, coincident with core_tick.
REQ-013 tick_done  out  1  single-cycle pulse when all active cores have reported done.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 tick_count  out  COUNT_W  completed ticks, modulo 2^COUNT_W.
REQ-016 error  out  1  sticky timeout flag.
REQ-017 error_core  out  NUM_CORES  cores still pending at timeout.
REQ-018 overrun  out  1  sticky: tick_req seen while busy.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, DONE, ERROR.
REQ-020 IDLE: tick_req=1 at edge N -> ISSUE; pending <= core_active_mask; timer <= 0.
REQ-021 ISSUE (cycle N+1): core_tick = registered pending mask, tick_ack=1; next state WAIT. If pending is 0, next state DONE.
REQ-022 In ISSUE and WAIT: pending <= pending & ~core_done every cycle; done bits of non-pending cores are ignored.
REQ-023 WAIT: if (pending & ~core_done)==0 -> DONE; else if timer==TIMEOUT_CYCLES-1 -> ERROR; else timer+1.
REQ-024 Completion takes precedence over timeout when both occur at the same edge.
REQ-025 DONE: tick_done=1 for one cycle; tick_count increments (wraps from all-ones to 0); next state IDLE.
REQ-026 ERROR: error=1 and error_core=pending, both latched on entry; tick_count is not incremented; the state holds until clear_error=1.
REQ-027 ERROR with clear_error=1 -> IDLE; error and error_core clear at that edge.
REQ-028 clear_error outside ERROR SHALL have no effect.
REQ-029 tick_req is accepted only in IDLE.
REQ-030 tick_req=1 in any other state is dropped and sets overrun; overrun clears only on reset.
REQ-031 Minimum tick period: accept at N, core_tick at N+1, earliest tick_done at N+3, earliest next accept at N+4.
REQ-032 core_tick, tick_ack and tick_done SHALL never be high for more than one consecutive cycle.
REQ-033 timer width SHALL be $clog2(TIMEOUT_CYCLES).

Reset
REQ-034 rst=1 at an edge forces, from any state including mid-WAIT: state IDLE, pending=0, timer=0, tick_count=0.
REQ-035 The same reset forces error, error_core, overrun, core_tick, tick_ack and tick_done to 0.
REQ-036 core_done pulses arriving during reset or in IDLE SHALL be ignored.

Structure
REQ-037 Shared package tick_seq_pkg SHALL hold the state encoding (3 bits) and the default widths.
REQ-038 All outputs SHALL be registered.
REQ-039 The only sub-module is tick_timeout_counter (load/enable/terminal-count); no other hierarchy.

Verification (NUM_CORES=4, TIMEOUT_CYCLES=16)
REQ-040 Mask 4'b1111, tick_req at cycle 0, done pulses at cycles 3,5,6,9 -> core_tick=4'b1111 at cycle 1, tick_done at cycle 10, tick_count=1.
REQ-041 Mask 4'b0101, only core 2 pulses done -> timeout at cycle 17 with error=1, error_core=4'b0001; clear_error -> IDLE with error=0; tick_count unchanged.
REQ-042 Mask 4'b0000 -> core_tick=0, tick_ack at cycle 1, tick_done at cycle 2.
REQ-043 tick_req held high throughout -> exactly one tick every 4 cycles, and overrun=1 after the first busy cycle.
REQ-044 Preload tick_count=2^COUNT_W-1 (force) and complete one tick -> tick_count=0; rst mid-WAIT -> all outputs 0 the next cycle, and a subsequent core_done is ignored.
